demux_stream_router: RTL and testbench



---
 rtl/demux_stream_pkg.sv | 15 +
 rtl/demux_stream_slot.sv | 39 +++
 rtl/demux_stream_router.sv | 113 +++++++++++
 tb/tb_demux_stream_router.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared definitions for the demux_stream_router block:
// the select-width helper and the default channel count.
package demux_stream_pkg;

    // Default number of output channels when the top is not overridden.
    localparam int DEMUX_DEFAULT_NCH = 8;

    // Select width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_stream_slot.sv
// One-entry holding slot for a single output channel of demux_stream_router.
// A load in the same cycle as a pop refills the slot, so a consumer that
// keeps ready high sees one word per cycle without a bubble.
module demux_stream_slot
    import demux_stream_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_p1;
    logic [DW-1:0] data_p1;

    // Slot register: load wins over pop, data is kept while the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p1 <= 1'b0;
            data_p1  <= '0;
        end else begin
            if (load) begin
                valid_p1 <= 1'b1;
                data_p1  <= load_data;
            end else if (pop) begin
                valid_p1 <= 1'b0;
            end
        end
    end

    assign valid = valid_p1;
    assign data  = data_p1;

endmodule

// File: rtl/demux_stream_router.sv
// demux_stream_router: registered 1-to-N_CH demultiplexer for valid/ready
// streams. Each channel owns a one-entry slot, so a stalled consumer only
// blocks words addressed to it. Selects that name no channel (possible when
// N_CH is not a power of two) are accepted, discarded and flagged on drop.
// Optional broadcast: define DEMUX_STREAM_BCAST_EN to add in_bcast, which
// writes one word into every slot at once when all of them are free.
module demux_stream_router
    import demux_stream_pkg::*;
#(
    parameter  int N_CH  = DEMUX_DEFAULT_NCH,
    parameter  int DW    = 1,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef DEMUX_STREAM_BCAST_EN
    input  logic               in_bcast,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [N_CH-1:0]    out_valid,
    input  logic [N_CH-1:0]    out_ready,
    output logic [N_CH*DW-1:0] out_data,
    output logic               drop
);

    // Select space padded to a power of two so any in_sel value indexes safely.
    localparam int N_PAD = 1 << SEL_W;

    logic [N_CH-1:0]  free;
    logic [N_PAD-1:0] free_pad;
    logic [N_CH-1:0]  load;
    logic [N_CH-1:0]  pop;
    logic             sel_legal;
    logic             xfer;
    logic             drop_next;
    logic             drop_p1;

    // A slot can take a word if it is empty or is being drained this cycle.
    assign free = ~out_valid | out_ready;
    assign pop  = out_valid & out_ready;

    // Unused select codes read as not-free here but are overridden below.
    always_comb begin
        free_pad           = '0;
        free_pad[N_CH-1:0] = free;
    end

    assign sel_legal = (int'(in_sel) < N_CH);

    // Ready depends only on slot state, out_ready and the select, never on in_valid.
    always_comb begin
        in_ready = sel_legal ? free_pad[in_sel] : 1'b1;
`ifdef DEMUX_STREAM_BCAST_EN
        if (in_bcast) begin
            in_ready = &free;
        end
`endif
    end

    assign xfer = in_valid & in_ready;

    // Decode an accepted word into slot loads, or into a drop for an illegal select.
    always_comb begin
        load      = '0;
        drop_next = 1'b0;
        if (xfer) begin
`ifdef DEMUX_STREAM_BCAST_EN
            if (in_bcast) begin
                load = '1;
            end else
`endif
            if (sel_legal) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (in_sel == SEL_W'(k)) begin
                        load[k] = 1'b1;
                    end
                end
            end else begin
                drop_next = 1'b1;
            end
        end
    end

    // One holding slot per channel; all share the input payload.
    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_stream_slot #(
            .DW(DW)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .pop       (pop[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*DW +: DW])
        );
    end

    // Drop flag: one-cycle pulse after a discarded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_p1 <= 1'b0;
        end else begin
            drop_p1 <= drop_next;
        end
    end

    assign drop = drop_p1;

endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: an 8-channel instance for routing, stall,
// throughput, reset and broadcast, and a 6-channel instance for illegal
// selects. Stimulus pushes expected words into per-channel queues; a monitor
// process compares slot state, data and drop against those queues.
module tb_demux_stream_router;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-driven inputs, index 0 = 8-channel DUT, index 1 = 6-channel DUT.
    logic        in_valid_v [2];
    logic [2:0]  sel_v      [2];
    logic [3:0]  data_v     [2];
    logic [7:0]  or_v       [2];
    logic        bc_v       [2];

    // Output views of both DUTs at a common width.
    logic        in_ready_v [2];
    logic        drop_v     [2];
    logic [7:0]  ov_v       [2];
    logic [31:0] od_v       [2];

    logic        a_in_ready, a_drop;
    logic [7:0]  a_out_valid;
    logic [31:0] a_out_data;
    logic        b_in_ready, b_drop;
    logic [5:0]  b_out_valid;
    logic [23:0] b_out_data;

    demux_stream_router #(.N_CH(8), .DW(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX_STREAM_BCAST_EN
        .in_bcast  (bc_v[0]),
`endif
        .in_valid  (in_valid_v[0]),
        .in_ready  (a_in_ready),
        .in_data   (data_v[0]),
        .in_sel    (sel_v[0]),
        .out_valid (a_out_valid),
        .out_ready (or_v[0]),
        .out_data  (a_out_data),
        .drop      (a_drop)
    );

    demux_stream_router #(.N_CH(6), .DW(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX_STREAM_BCAST_EN
        .in_bcast  (bc_v[1]),
`endif
        .in_valid  (in_valid_v[1]),
        .in_ready  (b_in_ready),
        .in_data   (data_v[1]),
        .in_sel    (sel_v[1]),
        .out_valid (b_out_valid),
        .out_ready (or_v[1][5:0]),
        .out_data  (b_out_data),
        .drop      (b_drop)
    );

    always_comb begin
        in_ready_v[0] = a_in_ready;
        in_ready_v[1] = b_in_ready;
        drop_v[0]     = a_drop;
        drop_v[1]     = b_drop;
        ov_v[0]       = a_out_valid;
        ov_v[1]       = {2'b00, b_out_valid};
        od_v[0]       = a_out_data;
        od_v[1]       = {8'h00, b_out_data};
    end

    // Reference model: per-channel FIFO of words accepted but not yet consumed.
    logic [3:0] exq   [16][$];
    logic [3:0] lastd [16];
    bit         drop_exp  [2];
    bit         last_acc  [2];
    bit         stalled   [2];
    logic [2:0] held_sel  [2];
    logic [3:0] held_data [2];

    function automatic int nch(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int q = 0; q < 16; q++) begin
            exq[q].delete();
            lastd[q] = 4'h0;
        end
        for (int d = 0; d < 2; d++) begin
            drop_exp[d] = 1'b0;
            last_acc[d] = 1'b0;
            stalled[d]  = 1'b0;
        end
    endtask

    // Called just before a rising edge: predict ready, record what the edge accepts.
    task automatic observe();
        for (int d = 0; d < 2; d++) begin
            int n;
            int s;
            bit er;
            bit acc;
            n = nch(d);
            s = int'(sel_v[d]);
            if (bc_v[d]) begin
                er = 1'b1;
                for (int k = 0; k < n; k++)
                    if (exq[d*8+k].size() != 0 && !or_v[d][k]) er = 1'b0;
            end else if (s < n) begin
                er = (exq[d*8+s].size() == 0) || or_v[d][s];
            end else begin
                er = 1'b1;
            end
            chk($sformatf("in_ready[dut%0d]", d), {31'b0, in_ready_v[d]}, {31'b0, er});
            if (stalled[d])
                assert (in_valid_v[d] && sel_v[d] == held_sel[d] && data_v[d] == held_data[d])
                    else $error("producer hold rule broken by stimulus on dut%0d", d);
            acc          = in_valid_v[d] && in_ready_v[d];
            stalled[d]   = in_valid_v[d] && !in_ready_v[d];
            held_sel[d]  = sel_v[d];
            held_data[d] = data_v[d];
            last_acc[d]  = acc;
            drop_exp[d]  = 1'b0;
            if (acc) begin
                if (bc_v[d]) begin
                    for (int k = 0; k < n; k++) begin
                        exq[d*8+k].push_back(data_v[d]);
                        lastd[d*8+k] = data_v[d];
                    end
                end else if (s < n) begin
                    exq[d*8+s].push_back(data_v[d]);
                    lastd[d*8+s] = data_v[d];
                end else begin
                    drop_exp[d] = 1'b1;
                end
            end
        end
    endtask

    // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic step();
        #7;
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int sel, input int data);
        int budget;
        in_valid_v[d] = 1'b1;
        sel_v[d]      = 3'(sel);
        data_v[d]     = 4'(data);
        budget        = 50;
        do begin
            step();
            budget--;
        end while (!last_acc[d] && budget > 0);
        if (!last_acc[d]) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: dut%0d sel %0d never accepted, required acceptance", d, sel);
        end
        in_valid_v[d] = 1'b0;
    endtask

    // Monitor: compare slot state after each edge, retire consumed words before the next.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    for (int k = 0; k < nch(d); k++) begin
                        int q;
                        logic [3:0] ed;
                        q  = d*8 + k;
                        ed = (exq[q].size() != 0) ? exq[q][0] : lastd[q];
                        chk($sformatf("out_valid[dut%0d ch%0d]", d, k),
                            {31'b0, ov_v[d][k]}, {31'b0, exq[q].size() != 0});
                        chk($sformatf("out_data[dut%0d ch%0d]", d, k),
                            {28'b0, od_v[d][k*4 +: 4]}, {28'b0, ed});
                    end
                    chk($sformatf("drop[dut%0d]", d), {31'b0, drop_v[d]}, {31'b0, drop_exp[d]});
                end
            end
            #4;
            if (rst_n) begin
                for (int d = 0; d < 2; d++)
                    for (int k = 0; k < nch(d); k++)
                        if (ov_v[d][k] && or_v[d][k] && exq[d*8+k].size() != 0)
                            void'(exq[d*8+k].pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int left;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0;
            sel_v[d]      = 3'd0;
            data_v[d]     = 4'd0;
            or_v[d]       = 8'hFF;
            bc_v[d]       = 1'b0;
        end
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid_a", {24'b0, a_out_valid}, 32'h0);
        chk("reset_out_data_a", a_out_data, 32'h0);
        chk("reset_drop_a", {31'b0, a_drop}, 32'h0);
        chk("reset_out_valid_b", {26'b0, b_out_valid}, 32'h0);
        rst_n = 1'b1;

        // Route one word to channel 3.
        in_valid_v[0] = 1'b1;
        sel_v[0]      = 3'd3;
        data_v[0]     = 4'hA;
        chk("t1_in_ready", {31'b0, a_in_ready}, 32'h1);
        step();
        in_valid_v[0] = 1'b0;
        chk("t1_out_valid", {24'b0, a_out_valid}, 32'h08);
        chk("t1_out_data", {28'b0, a_out_data[15:12]}, 32'hA);
        step();
        chk("t1_out_valid_after", {24'b0, a_out_valid}, 32'h00);

        // Back-pressure on channel 5 only.
        or_v[0] = 8'hDF;
        send(0, 5, 1);
        in_valid_v[0] = 1'b1;
        sel_v[0]      = 3'd5;
        data_v[0]     = 4'h2;
        chk("t2_stall", {31'b0, a_in_ready}, 32'h0);
        step();
        step();
        or_v[0][5] = 1'b1;
        step();
        chk("t2_accept", {31'b0, last_acc[0]}, 32'h1);
        chk("t2_ch5_data", {28'b0, a_out_data[23:20]}, 32'h2);
        send(0, 2, 3);
        chk("t2_third_accept", {31'b0, last_acc[0]}, 32'h1);
        step();

        // Full-rate stream over all channels.
        or_v[0] = 8'hFF;
        stalls  = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid_v[0] = 1'b1;
            sel_v[0]      = 3'(i % 8);
            data_v[0]     = 4'(i);
            step();
            if (!last_acc[0]) stalls++;
        end
        in_valid_v[0] = 1'b0;
        chk("t3_stalls", stalls, 0);
        step();
        step();

        // Illegal select on the 6-channel instance.
        in_valid_v[1] = 1'b1;
        sel_v[1]      = 3'd7;
        data_v[1]     = 4'hF;
        chk("t4_in_ready", {31'b0, b_in_ready}, 32'h1);
        step();
        in_valid_v[1] = 1'b0;
        chk("t4_drop", {31'b0, b_drop}, 32'h1);
        chk("t4_out_valid", {26'b0, b_out_valid}, 32'h0);
        step();
        chk("t4_drop_pulse", {31'b0, b_drop}, 32'h0);

        // Asynchronous reset while two channels hold words.
        or_v[0] = 8'h00;
        send(0, 0, 5);
        send(0, 1, 6);
        step();
        chk("t5_filled", {24'b0, a_out_valid}, 32'h03);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {24'b0, a_out_valid}, 32'h0);
        chk("t5_async_data", a_out_data, 32'h0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        or_v[0] = 8'hFF;
        send(0, 6, 12);
        chk("t5_after_reset", {24'b0, a_out_valid}, 32'h40);
        step();

`ifdef DEMUX_STREAM_BCAST_EN
        // Broadcast waits for the stalled channel 4, then fills every slot.
        or_v[0] = 8'hEF;
        send(0, 4, 7);
        bc_v[0]       = 1'b1;
        in_valid_v[0] = 1'b1;
        data_v[0]     = 4'h9;
        step();
        step();
        chk("t6_bcast_stall", {31'b0, a_in_ready}, 32'h0);
        or_v[0][4] = 1'b1;
        step();
        bc_v[0]       = 1'b0;
        in_valid_v[0] = 1'b0;
        chk("t6_bcast_valid", {24'b0, a_out_valid}, 32'hFF);
        chk("t6_bcast_data", a_out_data, 32'h99999999);
        step();
`endif

        // Randomised traffic on both instances, honouring the hold rule.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!stalled[d]) begin
                    in_valid_v[d] = ($urandom_range(0, 3) != 0);
                    sel_v[d]      = 3'($urandom_range(0, 7));
                    data_v[d]     = 4'($urandom);
`ifdef DEMUX_STREAM_BCAST_EN
                    bc_v[d]       = ($urandom_range(0, 7) == 0);
`endif
                end
                or_v[d] = 8'($urandom) | 8'($urandom);
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0;
            bc_v[d]       = 1'b0;
            or_v[d]       = 8'hFF;
        end
        repeat (3) step();
        left = 0;
        for (int q = 0; q < 16; q++) left += exq[q].size();
        chk("drain_empty", left, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
